// File: rtl/scroll_pkg.sv
// Shared types for the scrolling pixel generator: scroll modes, bounce
// direction and the packed upper/lower colour pair stored per buffer word.
package scroll_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        BOUNCE = 2'd3
    } scroll_mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } bounce_dir_t;

    // One buffer word: upper-half colour in the high bits, lower-half below.
    typedef struct packed {
        logic [2:0] upper;
        logic [2:0] lower;
    } rgb_pair_t;

    localparam int RGB_PAIR_W = $bits(rgb_pair_t);

    // The pause edge detector powers up as if the button were already high,
    // so a button held through reset does not count as a press.
    localparam logic PAUSE_PREV_RST = 1'b1;

endpackage

// File: rtl/pixel_buf_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// Read-before-write, so a same-address collision returns the old word.
module pixel_buf_ram
    import scroll_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  rgb_pair_t       wr_data,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output rgb_pair_t       rd_data
);

    rgb_pair_t mem_reg [DEPTH];
    rgb_pair_t rd_data_reg;

    // Write and registered read share one process; the read samples the
    // array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem_reg[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/scroll_pixel_gen.sv
// Scrolling pixel source for a split-scan LED panel. A virtual buffer wider
// than the panel is read at (scroll_pos + col); scroll_pos moves left, right
// or bounces on a programmable tick, and a button toggles pause.
module scroll_pixel_gen
    import scroll_pkg::*;
#(
    parameter int BUF_COLS    = 256,
    parameter int COLS        = 32,
    parameter int SCAN_ROWS   = 8,
    parameter int TICK_CYCLES = 8_500_000
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [$clog2(BUF_COLS)-1:0]           col,
    input  logic [$clog2(SCAN_ROWS)-1:0]          row,
    input  logic                                  pix_req,
    input  logic [1:0]                            scroll_mode,
    input  logic [2:0]                            speed,
    input  logic                                  pause_btn,
    input  logic                                  wr_en,
    input  logic [$clog2(BUF_COLS*SCAN_ROWS)-1:0] wr_addr,
    input  logic [5:0]                            wr_data,
    output logic [2:0]                            rgb1,
    output logic [2:0]                            rgb2,
    output logic                                  pix_valid,
    output logic [$clog2(BUF_COLS)-1:0]           scroll_pos,
    output logic                                  paused
);

    localparam int CW = $clog2(BUF_COLS);
    localparam int RW = $clog2(SCAN_ROWS);
    localparam int AW = $clog2(BUF_COLS * SCAN_ROWS);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [CW-1:0] POS_ONE   = CW'(1);
    localparam logic [CW-1:0] MAXB      = CW'(BUF_COLS - COLS);
    localparam logic [CW-1:0] MAXB_M1   = CW'(BUF_COLS - COLS - 1);

    logic [TW-1:0] tick_reg;
    logic [2:0]    div_reg;
    logic [CW-1:0] pos_reg, pos_next;
    bounce_dir_t   dir_reg, dir_next;
    logic          paused_reg;
    logic          pause_prev_reg;
    logic          pix_valid_reg;
    logic          have_data_reg;

    scroll_mode_t  mode;
    logic          tick;
    logic          div_hit;
    logic          step;
    logic          pause_rise;

    logic [CW-1:0] col_sum;
    logic [AW-1:0] rd_addr;
    rgb_pair_t     ram_q;
    logic [RGB_PAIR_W-1:0] rgb_word;

    assign mode       = scroll_mode_t'(scroll_mode);
    assign tick       = (tick_reg == TICK_LAST);
    // ">=" rather than "==" so that lowering speed below the running
    // divider forces a step on the very next tick.
    assign div_hit    = (div_reg >= speed);
    assign step       = tick && div_hit && !paused_reg && (mode != HOLD);
    assign pause_rise = pause_btn && !pause_prev_reg;

    // Free-running base tick counter, unaffected by mode or pause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_reg <= '0;
        end else if (tick) begin
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_reg + TICK_ONE;
        end
    end

    // Speed divider counts base ticks and clears whenever it releases a step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_reg <= '0;
        end else if (tick) begin
            div_reg <= div_hit ? 3'd0 : div_reg + 3'd1;
        end
    end

    // Pause toggles on each button rising edge; a step in the same cycle
    // was already qualified with the old pause value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause_prev_reg <= PAUSE_PREV_RST;
            paused_reg     <= 1'b0;
        end else begin
            pause_prev_reg <= pause_btn;
            if (pause_rise) begin
                paused_reg <= !paused_reg;
            end
        end
    end

    // Scroll position and bounce direction state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_reg <= '0;
            dir_reg <= DIR_UP;
        end else begin
            pos_reg <= pos_next;
            dir_reg <= dir_next;
        end
    end

    // Next scroll position; the mode is sampled only when a step fires.
    always_comb begin
        pos_next = pos_reg;
        dir_next = dir_reg;
        if (step) begin
            case (mode)
                LEFT: begin
                    pos_next = pos_reg + POS_ONE;
                end
                RIGHT: begin
                    pos_next = pos_reg - POS_ONE;
                end
                BOUNCE: begin
                    if (pos_reg > MAXB) begin
                        // Entered bounce beyond the legal window: snap back.
                        pos_next = MAXB;
                        dir_next = DIR_DOWN;
                    end else if (pos_reg == MAXB) begin
                        pos_next = MAXB_M1;
                        dir_next = DIR_DOWN;
                    end else if (pos_reg == '0) begin
                        pos_next = POS_ONE;
                        dir_next = DIR_UP;
                    end else if (dir_reg == DIR_UP) begin
                        pos_next = pos_reg + POS_ONE;
                    end else begin
                        pos_next = pos_reg - POS_ONE;
                    end
                end
                default: begin
                    pos_next = pos_reg;
                end
            endcase
        end
    end

    // Read address uses the position before any step taken this cycle.
    assign col_sum = pos_reg + col;
    assign rd_addr = {col_sum, row};

    pixel_buf_ram #(
        .DEPTH (BUF_COLS * SCAN_ROWS),
        .AW    (AW)
    ) u_pixel_buf_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (rgb_pair_t'(wr_data)),
        .rd_en   (pix_req),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Read handshake: valid follows a request by one cycle; have_data masks
    // the un-reset RAM output register until a read completes after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid_reg <= 1'b0;
            have_data_reg <= 1'b0;
        end else begin
            pix_valid_reg <= pix_req;
            have_data_reg <= have_data_reg || pix_req;
        end
    end

    generate
        for (genvar gi = 0; gi < RGB_PAIR_W; gi++) begin : g_rgb_mask
            assign rgb_word[gi] = ram_q[gi] & have_data_reg;
        end
    endgenerate

    assign rgb1       = rgb_word[5:3];
    assign rgb2       = rgb_word[2:0];
    assign pix_valid  = pix_valid_reg;
    assign scroll_pos = pos_reg;
    assign paused     = paused_reg;

endmodule
